gpr_file: RTL

//  Parametrised general-purpose register file; successor to the single-register EBX block.

---
 rtl/gpr_file.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gpr_file.sv
// gpr_file: x86-style register file with sub-register writes,
// two bypassed read ports and a per-register busy scoreboard.
module gpr_file #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      NUM_REGS  = 8,
    parameter int unsigned      ADDR_W    = 3,
    parameter int unsigned      EBX_INDEX = 3,
    parameter logic [WIDTH-1:0] EBX_RESET = 'h888
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [WIDTH-1:0]  rd_a_data,
    output logic              rd_a_busy,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [WIDTH-1:0]  rd_b_data,
    output logic              rd_b_busy,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_mode,
    input  logic [WIDTH-1:0]  wr_data
);

    logic [WIDTH-1:0]    r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    logic                w_wr_en;
    logic [WIDTH-1:0]    w_wr_old;
    logic [WIDTH-1:0]    w_merged;
    logic [WIDTH-1:0]    w_a_reg;
    logic [WIDTH-1:0]    w_b_reg;
    logic                w_a_bsy;
    logic                w_b_bsy;
    logic                w_rsv_bsy;
    logic                w_a_byp;
    logic                w_b_byp;
    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_rsv_hit;

    // Out-of-range indices simply never match, so they read 0 / not busy.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_old  = '0;
        w_a_reg   = '0;
        w_b_reg   = '0;
        w_a_bsy   = 1'b0;
        w_b_bsy   = 1'b0;
        w_rsv_bsy = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                w_wr_en  = wr_valid & reset;
                w_wr_old = r_regs[i];
            end
            if (rd_a_addr == ADDR_W'(i)) begin
                w_a_reg = r_regs[i];
                w_a_bsy = r_busy[i];
            end
            if (rd_b_addr == ADDR_W'(i)) begin
                w_b_reg = r_regs[i];
                w_b_bsy = r_busy[i];
            end
            if (rsv_addr == ADDR_W'(i)) begin
                w_rsv_bsy = r_busy[i];
            end
        end
    end

    always_comb begin
        w_merged = w_wr_old;
        case (wr_mode)
            2'b00:   w_merged        = wr_data;
            2'b01:   w_merged[15:0]  = wr_data[15:0];
            2'b10:   w_merged[7:0]   = wr_data[7:0];
            2'b11:   w_merged[15:8]  = wr_data[7:0];
            default: w_merged        = w_wr_old;
        endcase
    end

    assign w_a_byp   = w_wr_en && (wr_addr == rd_a_addr);
    assign w_b_byp   = w_wr_en && (wr_addr == rd_b_addr);

    assign rd_a_data = w_a_byp ? w_merged : w_a_reg;
    assign rd_b_data = w_b_byp ? w_merged : w_b_reg;
    assign rd_a_busy = reset && w_a_bsy && !w_a_byp;
    assign rd_b_busy = reset && w_b_bsy && !w_b_byp;

    // A write landing this cycle frees the slot for a new reservation.
    assign rsv_ready = !reset || !w_rsv_bsy ||
                       (w_wr_en && (wr_addr == rsv_addr));

    always_comb begin
        w_wr_hit  = '0;
        w_rsv_hit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_wr_hit[i]  = w_wr_en && (wr_addr == ADDR_W'(i));
            w_rsv_hit[i] = reset && rsv_valid && rsv_ready &&
                           (rsv_addr == ADDR_W'(i));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == EBX_INDEX) ? EBX_RESET : '0;
            end
            r_busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[i]) begin
                    r_regs[i] <= w_merged;
                end
                if (w_rsv_hit[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_hit[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule
